// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar sweep controller: state codes (also the db_estado encoding)
// and a width helper for parameter-dependent buses.
package sonar_pkg;

  typedef enum logic [3:0] {
    StInicial         = 4'd0,
    StPreparacao      = 4'd1,
    StEspera          = 4'd2,
    StMede            = 4'd3,
    StAguardaMedida   = 4'd4,
    StTransmite       = 4'd5,
    StEsperaSerial    = 4'd6,
    StAtualizaSerial  = 4'd7,
    StAtualizaPosicao = 4'd8,
    StFim             = 4'd9
  } estado_e;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned largura(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulus-M up counter with synchronous clear; fim flags the terminal count M-1.
module contador_m
  import sonar_pkg::*;
#(
  parameter int unsigned M = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int unsigned W = largura(M);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (zera) begin
      cnt_q <= '0;
    end else if (conta) begin
      cnt_q <= fim ? '0 : cnt_q + W'(1);
    end
  end

  assign fim = (cnt_q == W'(M - 1));

endmodule

// File: rtl/sonar_uc_param.sv
// Sonar control unit: steps a servo through N_POS positions, triggers a measurement at each
// and ships N_CHAR serial characters per result, with settling delay and measurement timeout.
module sonar_uc_param
  import sonar_pkg::*;
#(
  parameter int unsigned N_POS     = 8,
  parameter int unsigned N_CHAR    = 4,
  parameter int unsigned T_ESPERA  = 50_000_000,
  parameter int unsigned T_TIMEOUT = 2_000_000,
  parameter int unsigned PING_PONG = 0,
  parameter int unsigned CONTINUO  = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ligar,
  input  logic                        pronto_medida,
  input  logic                        pronto_serial,
  output logic                        medir,
  output logic                        partida_serial,
  output logic [largura(N_POS)-1:0]   posicao,
  output logic [largura(N_CHAR)-1:0]  indice_char,
  output logic                        erro_medida,
  output logic                        fim_varredura,
  output logic [3:0]                  db_estado
);

  localparam int unsigned PW = largura(N_POS);
  localparam int unsigned CW = largura(N_CHAR);
  localparam logic [PW-1:0] PosMax  = PW'(N_POS - 1);
  localparam logic [CW-1:0] CharMax = CW'(N_CHAR - 1);

  estado_e       state_q, state_d;
  logic [PW-1:0] pos_q, pos_nxt;
  logic [CW-1:0] char_q, char_nxt;
  logic          desce_q, desce_nxt;  // 1 while ping-pong sweep heads toward position 0
  logic          wrap;
  logic          fim_espera, fim_timeout;

  contador_m #(.M(T_ESPERA)) u_timer (
    .clock (clock),
    .reset (reset),
    .zera  (state_q == StPreparacao),
    .conta (state_q == StEspera),
    .fim   (fim_espera)
  );

  contador_m #(.M(T_TIMEOUT)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (state_q == StMede),
    .conta (state_q == StAguardaMedida),
    .fim   (fim_timeout)
  );

  // Next position/character values, applied only in the matching update state.
  always_comb begin
    pos_nxt   = pos_q;
    desce_nxt = desce_q;
    wrap      = 1'b0;
    if (PING_PONG == 0) begin
      wrap    = (pos_q == PosMax);
      pos_nxt = wrap ? '0 : pos_q + PW'(1);
    end else if (!desce_q) begin
      wrap      = (pos_q == PosMax);
      pos_nxt   = wrap ? pos_q - PW'(1) : pos_q + PW'(1);
      desce_nxt = wrap;
    end else begin
      wrap      = (pos_q == '0);
      pos_nxt   = wrap ? pos_q + PW'(1) : pos_q - PW'(1);
      desce_nxt = !wrap;
    end
    char_nxt = (char_q == CharMax) ? '0 : char_q + CW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos_q   <= '0;
      char_q  <= '0;
      desce_q <= 1'b0;
    end else if (state_q == StPreparacao) begin
      pos_q   <= '0;
      char_q  <= '0;
      desce_q <= 1'b0;
    end else if (state_q == StAtualizaSerial) begin
      char_q <= char_nxt;
    end else if (state_q == StAtualizaPosicao) begin
      pos_q   <= pos_nxt;
      desce_q <= desce_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StInicial;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInicial:         if (ligar) state_d = StPreparacao;
      StPreparacao:      state_d = StEspera;
      StEspera:          if (fim_espera) state_d = StMede;
      StMede:            state_d = StAguardaMedida;
      StAguardaMedida: begin
        if (pronto_medida) begin
          state_d = StTransmite;
        end else if (fim_timeout) begin
          state_d = StAtualizaPosicao;
        end
      end
      StTransmite:       state_d = StEsperaSerial;
      StEsperaSerial:    if (pronto_serial) state_d = StAtualizaSerial;
      StAtualizaSerial:  state_d = (char_q == CharMax) ? StAtualizaPosicao : StTransmite;
      StAtualizaPosicao: state_d = (wrap && CONTINUO == 0) ? StFim : StEspera;
      StFim:             if (!ligar) state_d = StInicial;
      default:           state_d = StInicial;
    endcase
    if (!ligar && state_q != StInicial && state_q != StFim) begin
      state_d = StInicial;
    end
  end

  always_comb begin
    medir          = (state_q == StMede);
    partida_serial = (state_q == StTransmite);
    erro_medida    = (state_q == StAguardaMedida) && fim_timeout;
    fim_varredura  = (state_q == StAtualizaPosicao) && wrap;
    posicao        = pos_q;
    indice_char    = char_q;
    db_estado      = state_q;
  end

endmodule

// File: doc/sonar_uc_param.md
SONAR_UC_PARAM -- requirements
Module: sonar_uc_param

Interface
REQ-001 Parameter N_POS, default 8: number of servo positions per sweep (2..256).
REQ-002 Parameter N_CHAR, default 4: serial characters sent per measurement (1..16).
REQ-003 Parameter T_ESPERA, default 50_000_000: clock cycles of servo settling before each measurement (>=2).
REQ-004 Parameter T_TIMEOUT, default 2_000_000: maximum cycles waiting for pronto_medida (>=2).
REQ-005 Parameter PING_PONG, default 0: 0 = position wraps N_POS-1 -> 0; 1 = position reverses direction at either end.
REQ-006 Parameter CONTINUO, default 1: 1 = sweep repeats; 0 = stop after one full sweep.
REQ-007 clock  input  1  system clock, all state changes on the rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-009 ligar  input  1  level enable; 0 aborts the operation.
REQ-010 pronto_medida  input  1  one-cycle pulse, measurement complete.
REQ-011 pronto_serial  input  1  one-cycle pulse, character transmitted.
REQ-012 medir  output  1  one-cycle pulse, start a measurement.
REQ-013 partida_serial  output  1  one-cycle pulse, start a character transmission.
REQ-014 posicao  output  $clog2(N_POS)  current servo position index.
REQ-015 indice_char  output  $clog2(N_CHAR) (min 1)  index of the character being sent.
REQ-016 erro_medida  output  1  one-cycle pulse, measurement timeout.
REQ-017 fim_varredura  output  1  one-cycle pulse when the last position of a sweep completes.
REQ-018 db_estado  output  4  current state code.

Function
REQ-019 States and codes: INICIAL 0, PREPARACAO 1, ESPERA 2, MEDE 3, AGUARDA_MEDIDA 4, TRANSMITE 5, ESPERA_SERIAL 6, ATUALIZA_SERIAL 7, ATUALIZA_POSICAO 8, FIM 9; unused codes go to INICIAL.
REQ-020 INICIAL -> PREPARACAO when ligar=1; PREPARACAO -> ESPERA unconditionally, clearing the timer, posicao, indice_char and direction (up).
REQ-021 ESPERA counts the internal timer and goes to MEDE on the cycle where the timer reaches T_ESPERA-1; it then clears the timer.
REQ-022 MEDE asserts medir for exactly one cycle, then goes to AGUARDA_MEDIDA with the timeout counter cleared.
REQ-023 AGUARDA_MEDIDA -> TRANSMITE on pronto_medida; otherwise, when the timeout counter reaches T_TIMEOUT-1, it pulses erro_medida and goes to ATUALIZA_POSICAO (no transmission); pronto_medida wins if both occur in the same cycle.
REQ-024 TRANSMITE asserts partida_serial for one cycle -> ESPERA_SERIAL; ESPERA_SERIAL -> ATUALIZA_SERIAL on pronto_serial.
REQ-025 ATUALIZA_SERIAL: when indice_char=N_CHAR-1, clear indice_char -> ATUALIZA_POSICAO; otherwise increment indice_char -> TRANSMITE.
REQ-026 ATUALIZA_POSICAO, PING_PONG=0: posicao increments and wraps N_POS-1 -> 0; fim_varredura pulses on the wrap.
REQ-027 ATUALIZA_POSICAO, PING_PONG=1: posicao moves in the current direction and reverses at 0 and N_POS-1 without repeating an endpoint; fim_varredura pulses when it leaves an endpoint after the reversal.
REQ-028 After ATUALIZA_POSICAO: if fim_varredura and CONTINUO=0 -> FIM; otherwise -> ESPERA.
REQ-029 FIM holds all pulses low and returns to INICIAL when ligar=0.
REQ-030 ligar=0 in any state other than INICIAL or FIM forces INICIAL on the next edge; counters keep their values until PREPARACAO.
REQ-031 All outputs are Moore outputs, decoded from the registered state and counters; no output depends combinationally on an input.
REQ-032 Pulses on pronto_medida or pronto_serial outside their waiting states are ignored.

Reset
REQ-033 While reset=0, the state is INICIAL and the timer, timeout counter, posicao, indice_char and direction are 0 (up); all pulse outputs are 0 and db_estado=0.
REQ-034 Deassertion takes effect on the first rising edge after reset returns to 1; a reset mid-transmission abandons the transmission with no further partida_serial.

Structure
REQ-035 State codes and the db_estado encoding reside in a shared package, sonar_pkg.
REQ-036 The settling timer and the timeout counter are separate instances of one sub-module, contador_m (modulus parameter, zera/conta inputs, fim output).

Verification
REQ-037 N_POS=4, N_CHAR=2, T_ESPERA=5, CONTINUO=1, PING_PONG=0, every medir answered after 3 cycles and every partida_serial after 4 -> posicao 0,1,2,3,0; two partida_serial per position; fim_varredura at 3->0.
REQ-038 Same setup with PING_PONG=1 -> posicao 0,1,2,3,2,1,0,1.
REQ-039 T_TIMEOUT=10, pronto_medida never asserted -> erro_medida 10 cycles after medir; no partida_serial; posicao advances.
REQ-040 CONTINUO=0, N_POS=2 -> reaches FIM (db_estado=9) after the second position; ligar=0 -> INICIAL.
REQ-041 ligar dropped in ESPERA_SERIAL -> INICIAL next edge; re-enable -> posicao=0, indice_char=0.
REQ-042 reset=0 asynchronously in AGUARDA_MEDIDA -> all outputs 0 immediately, db_estado=0.
